hamming_dec_engine: RTL and testbench
=====================================

Name: hamming_dec_engine

Overview:
- Memory-walking SECDED decoder; direct downstream consumer of the program-1 Hamming encoder output.
- Reads NUM_MSG 16-bit codewords from data memory, computes the syndrome and overall parity, corrects single-bit errors, flags double-bit errors.
- Writes the 11-bit messages plus 2-bit status back to memory.
- Shares the byte-wide data memory port and uses the Req/Done start handshake of the top level.

Parameters:
- NUM_MSG, 15: number of codewords processed per run.
- SRC_BASE, 30: byte address of the first codeword; low byte at even address, high byte at +1.
- DST_BASE, 0: byte address of the first decoded message; low byte at even address, high byte at +1.
- ADDR_W, 8: memory address width.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Req  in  1  start pulse; sampled only in IDLE or DONE.
- Done  out  1  high from run completion until the next accepted Req.
- Mem_Addr  out  ADDR_W  byte address to data memory.
- Mem_WrEn  out  1  write strobe, one byte per cycle.
- Mem_WrData  out  8  write data.
- Mem_RdData  in  8  read data; combinational (async) read of Mem_Addr, valid in the same cycle.
- Err1_Cnt  out  5  single-error count (STATS_EN only).
- Err2_Cnt  out  5  double-error count (STATS_EN only).

Behaviour:
Reset values:
- Reset_n low forces IDLE immediately (asynchronous).
- Done=0, Mem_WrEn=0, Mem_Addr=0, Mem_WrData=0, index i=0, counters=0.
- Reset mid-run abandons the run. Bytes already written stay written; no further writes occur.

FSM states: IDLE, RD_LO, RD_HI, DEC, WR_LO, WR_HI, NEXT, DONE.
- IDLE/DONE: Req=1 -> RD_LO, i<=0, Done<=0. Req=0 -> stay.
- RD_LO: Mem_Addr=SRC_BASE+2i; latch cw[7:0].
- RD_HI: Mem_Addr=SRC_BASE+2i+1; latch cw[15:8].
- DEC: register the decode result.
- WR_LO: Mem_Addr=DST_BASE+2i, Mem_WrEn=1, Mem_WrData=d[8:1].
- WR_HI: Mem_Addr=DST_BASE+2i+1, Mem_WrEn=1, Mem_WrData={F[1:0],3'b000,d[11:9]}.
- NEXT: if i==NUM_MSG-1 -> DONE (Done<=1); else i<=i+1 and go to RD_LO.

Timing and handshake:
- 6 cycles per message. Done rises 6*NUM_MSG cycles after the Req-sampling edge (90 for defaults).
- Req while busy (any state other than IDLE/DONE) is ignored.
- Mem_WrEn is 0 in every state except WR_LO and WR_HI.

Codeword layout (bit index = Hamming position):
- 15..9 = d11..d5, 8 = p8, 7..5 = d4..d2, 4 = p4, 3 = d1, 2 = p2, 1 = p1, 0 = p0 (overall parity).

Decode rules:
- S[3:0] = XOR of the indices of all set bits in cw[15:1].
- P = XOR of cw[15:0].
- S==0, P==0: no error; F=00; data taken as received.
- P==1: single error at position S (S==0 means p0 itself); flip that bit; F=01.
- S!=0, P==0: double error; F=10; data uncorrected as received.
- F=11 is never produced.
- Syndrome/correction logic is purely combinational from the latched codeword; only the result is registered.

Optional Feature:
STATS_EN
- Defined:
  - Err1_Cnt increments on each F=01 result; Err2_Cnt increments on each F=10 result.
  - Both counters increment in DEC, saturate at 31, and clear on an accepted Req and on reset.
- Undefined: Err1_Cnt and Err2_Cnt are tied to 0; no counter flops are inferred.

Test Plan:
- Codeword 16'h0000 at bytes 30/31 -> mem[0]=8'h00, mem[1]=8'h00; Done rises at cycle 90 after Req.
- Codeword 16'hFFFF (msg 11'h7FF, no error) -> mem[0]=8'hFF, mem[1]=8'h07.
- 16'hFFDF (bit 5 / d2 flipped) -> corrected: mem[0]=8'hFF, mem[1]=8'h47. 16'hFFFE (p0 flipped) -> same bytes.
- 16'hFFF9 (bits 1, 2 flipped) -> mem[0]=8'hFF, mem[1]=8'h87. With STATS_EN over 15 such words: Err2_Cnt=15, Err1_Cnt=0.
- Req re-pulsed at cycle 20 of a run -> ignored; exactly 30 write strobes; Done timing unchanged.
- Reset_n low during WR_LO of message 4 -> Mem_WrEn drops immediately; Done=0; mem[9..29] untouched. A new Req after release redoes the full run correctly.

Source files
------------

// File: rtl/hamming_dec_engine.sv
// SECDED decoder that walks NUM_MSG codewords in byte memory and writes back the messages with a 2-bit status.
// Optional STATS_EN build adds saturating single/double error counters.
module hamming_dec_engine #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int ADDR_W   = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req,
  output logic              Done,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_WrEn,
  output logic [7:0]        Mem_WrData,
  input  logic [7:0]        Mem_RdData,
  output logic [4:0]        Err1_Cnt,
  output logic [4:0]        Err2_Cnt
);

  localparam int IDX_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_MSG - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, DEC, WR_LO, WR_HI, NEXT, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      cw_q, cw_d;
  logic [10:0]      msg_q, msg_d;
  logic [1:0]       flag_q, flag_d;
  logic             done_q, done_d;

  logic [3:0]        syn;
  logic              par;
  logic [15:0]       fixedCw;
  logic [1:0]        flagC;
  logic [10:0]       msgC;
  logic [ADDR_W-1:0] srcAddr, dstAddr;
  logic              reqAccept;

  assign reqAccept = ((state_q == IDLE) || (state_q == DONE)) && Req;
  assign srcAddr   = ADDR_W'(SRC_BASE) + ADDR_W'({idx_q, 1'b0});
  assign dstAddr   = ADDR_W'(DST_BASE) + ADDR_W'({idx_q, 1'b0});

  // Syndrome is the XOR of set-bit positions; overall parity decides single vs double error.
  always_comb begin
    syn = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (cw_q[k]) syn = syn ^ 4'(k);
    end
    par     = ^cw_q;
    fixedCw = cw_q;
    flagC   = 2'b00;
    if (par) begin
      fixedCw[syn] = ~cw_q[syn];
      flagC        = 2'b01;
    end else if (syn != 4'd0) begin
      flagC = 2'b10;
    end
    msgC = {fixedCw[15:9], fixedCw[7:5], fixedCw[3]};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cw_q    <= '0;
      msg_q   <= '0;
      flag_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cw_q    <= cw_d;
      msg_q   <= msg_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cw_d       = cw_q;
    msg_d      = msg_q;
    flag_d     = flag_q;
    done_d     = done_q;
    Mem_Addr   = '0;
    Mem_WrEn   = 1'b0;
    Mem_WrData = 8'h00;
    case (state_q)
      IDLE, DONE: begin
        if (Req) begin
          state_d = RD_LO;
          idx_d   = '0;
          done_d  = 1'b0;
        end
      end
      RD_LO: begin
        Mem_Addr   = srcAddr;
        cw_d[7:0]  = Mem_RdData;
        state_d    = RD_HI;
      end
      RD_HI: begin
        Mem_Addr   = srcAddr + ADDR_ONE;
        cw_d[15:8] = Mem_RdData;
        state_d    = DEC;
      end
      DEC: begin
        msg_d   = msgC;
        flag_d  = flagC;
        state_d = WR_LO;
      end
      WR_LO: begin
        Mem_Addr   = dstAddr;
        Mem_WrEn   = 1'b1;
        Mem_WrData = msg_q[7:0];
        state_d    = WR_HI;
      end
      WR_HI: begin
        Mem_Addr   = dstAddr + ADDR_ONE;
        Mem_WrEn   = 1'b1;
        Mem_WrData = {flag_q, 3'b000, msg_q[10:8]};
        state_d    = NEXT;
      end
      NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = RD_LO;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Done = done_q;

`ifdef STATS_EN
  logic [4:0] err1_q, err2_q;

  // Counters follow the decode result as it is registered, saturating at 31.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      err1_q <= '0;
      err2_q <= '0;
    end else if (reqAccept) begin
      err1_q <= '0;
      err2_q <= '0;
    end else if (state_q == DEC) begin
      if ((flagC == 2'b01) && (err1_q != 5'd31)) err1_q <= err1_q + 5'd1;
      if ((flagC == 2'b10) && (err2_q != 5'd31)) err2_q <= err2_q + 5'd1;
    end
  end

  assign Err1_Cnt = err1_q;
  assign Err2_Cnt = err2_q;
`else
  logic unusedReq;
  assign unusedReq = reqAccept;
  assign Err1_Cnt  = 5'd0;
  assign Err2_Cnt  = 5'd0;
`endif

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Randomized self-checking bench for hamming_dec_engine: an encode-and-corrupt model predicts every write byte.
// Counter checks follow the STATS_EN build macro.
module tb_hamming_dec_engine;

  localparam int NUM = 15;
  localparam int SRC = 30;
  localparam int DST = 0;
  localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Req = 1'b0;
  logic       Done;
  logic [7:0] Mem_Addr;
  logic       Mem_WrEn;
  logic [7:0] Mem_WrData;
  logic [7:0] Mem_RdData;
  logic [4:0] Err1_Cnt;
  logic [4:0] Err2_Cnt;

  logic [7:0] mem [256];
  logic [7:0] expLo [NUM];
  logic [7:0] expHi [NUM];
  wr_t        expQ [$];
  int         exp1, exp2;
  int         checks = 0;
  int         failures = 0;
  int         wrCount = 0;

  hamming_dec_engine #(.NUM_MSG(NUM), .SRC_BASE(SRC), .DST_BASE(DST), .ADDR_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Done(Done),
    .Mem_Addr(Mem_Addr), .Mem_WrEn(Mem_WrEn), .Mem_WrData(Mem_WrData),
    .Mem_RdData(Mem_RdData), .Err1_Cnt(Err1_Cnt), .Err2_Cnt(Err2_Cnt)
  );

  always #5 Clk = ~Clk;

  assign Mem_RdData = mem[Mem_Addr];

  always @(posedge Clk) begin
    if (Mem_WrEn) mem[Mem_Addr] = Mem_WrData;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every write strobe must match the next predicted (address, byte) pair.
  always @(negedge Clk) begin
    wr_t e;
    if (!Reset_n) begin
      checkOutput("wren_in_reset", {31'd0, Mem_WrEn}, 32'd0);
    end else if (Mem_WrEn) begin
      wrCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", {24'd0, Mem_Addr}, 32'hFFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_addr", {24'd0, Mem_Addr}, {24'd0, e.addr});
        checkOutput("wr_data", {24'd0, Mem_WrData}, {24'd0, e.data});
      end
    end
  end

  function automatic logic [15:0] encode(input logic [10:0] msg);
    logic [15:0] cw;
    logic        par;
    cw = '0;
    for (int d = 0; d < 11; d++) cw[DPOS[d]] = msg[d];
    for (int p = 0; p < 4; p++) begin
      par = 1'b0;
      for (int pos = 1; pos < 16; pos++) begin
        if (((pos >> p) & 1) == 1 && pos != (1 << p)) par = par ^ cw[pos];
      end
      cw[1 << p] = par;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [15:0] makeMask(input int n);
    logic [15:0] m;
    int a, b;
    m = '0;
    a = 0;
    if (n >= 1) begin
      a = int'($urandom_range(0, 15));
      m[a] = 1'b1;
    end
    if (n == 2) begin
      do b = int'($urandom_range(0, 15)); while (b == a);
      m[b] = 1'b1;
    end
    return m;
  endfunction

  // Expected result follows from how many bits were corrupted, not from the syndrome.
  task automatic setWord(input int idx, input logic [10:0] msg, input logic [15:0] mask);
    logic [15:0] cw;
    logic [10:0] outMsg;
    logic [1:0]  f;
    int          nf;
    cw = encode(msg) ^ mask;
    mem[SRC + 2*idx]     = cw[7:0];
    mem[SRC + 2*idx + 1] = cw[15:8];
    nf = $countones(mask);
    outMsg = msg;
    f = 2'b00;
    if (nf == 1) begin
      f = 2'b01;
      exp1++;
    end else if (nf == 2) begin
      f = 2'b10;
      exp2++;
      for (int d = 0; d < 11; d++) outMsg[d] = cw[DPOS[d]];
    end
    expLo[idx] = outMsg[7:0];
    expHi[idx] = {f, 3'b000, outMsg[10:8]};
  endtask

  task automatic applyStimulus(input int mode);
    exp1 = 0;
    exp2 = 0;
    for (int i = 0; i < NUM; i++) begin
      setWord(i, 11'($urandom), makeMask(mode < 3 ? mode : int'($urandom_range(0, 2))));
    end
  endtask

  task automatic queueExpected();
    wr_t e;
    expQ.delete();
    for (int i = 0; i < NUM; i++) begin
      e.addr = 8'(DST + 2*i);     e.data = expLo[i]; expQ.push_back(e);
      e.addr = 8'(DST + 2*i + 1); e.data = expHi[i]; expQ.push_back(e);
    end
  endtask

  task automatic checkStats();
`ifdef STATS_EN
    checkOutput("err1_cnt", {27'd0, Err1_Cnt}, exp1);
    checkOutput("err2_cnt", {27'd0, Err2_Cnt}, exp2);
`else
    checkOutput("err1_cnt_tied", {27'd0, Err1_Cnt}, 32'd0);
    checkOutput("err2_cnt_tied", {27'd0, Err2_Cnt}, 32'd0);
`endif
  endtask

  task automatic runAndCheck(input bit rePulse);
    int cyc;
    bit got;
    queueExpected();
    wrCount = 0;
    @(negedge Clk) Req = 1'b1;
    @(posedge Clk);
    #1 checkOutput("done_cleared", {31'd0, Done}, 32'd0);
    @(negedge Clk) Req = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (cyc < 200 && !got) begin
      @(posedge Clk);
      #1;
      cyc++;
      if (Done) got = 1'b1;
      if (rePulse && cyc == 20) Req = 1'b1;
      if (rePulse && cyc == 21) Req = 1'b0;
    end
    checkOutput("done_latency", cyc, 90);
    repeat (2) @(negedge Clk);
    checkOutput("done_held", {31'd0, Done}, 32'd1);
    checkOutput("write_count", wrCount, 2*NUM);
    checkOutput("queue_drained", expQ.size(), 0);
    for (int i = 0; i < NUM; i++) begin
      checkOutput("mem_lo", {24'd0, mem[DST + 2*i]}, {24'd0, expLo[i]});
      checkOutput("mem_hi", {24'd0, mem[DST + 2*i + 1]}, {24'd0, expHi[i]});
    end
    checkStats();
  endtask

  initial begin
    int n;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    $display("[TB] start");
    repeat (3) @(negedge Clk);
    checkOutput("rst_done", {31'd0, Done}, 32'd0);
    checkOutput("rst_wren", {31'd0, Mem_WrEn}, 32'd0);
    checkOutput("rst_addr", {24'd0, Mem_Addr}, 32'd0);
    checkOutput("rst_wrdata", {24'd0, Mem_WrData}, 32'd0);
    checkOutput("rst_err1", {27'd0, Err1_Cnt}, 32'd0);
    checkOutput("rst_err2", {27'd0, Err2_Cnt}, 32'd0);
    Reset_n = 1'b1;

    // All-zero codewords.
    exp1 = 0; exp2 = 0;
    for (int i = 0; i < NUM; i++) setWord(i, 11'h000, 16'h0000);
    runAndCheck(1'b0);
    checkOutput("zero_mem0", {24'd0, mem[0]}, 32'h00);
    checkOutput("zero_mem1", {24'd0, mem[1]}, 32'h00);

    // Hand-computed words pin the model: FFFF, FFDF, FFFE, FFF9.
    checkOutput("encode_7ff", {16'd0, encode(11'h7FF)}, 32'hFFFF);
    exp1 = 0; exp2 = 0;
    setWord(0, 11'h7FF, 16'h0000);
    setWord(1, 11'h7FF, 16'h0020);
    setWord(2, 11'h7FF, 16'h0001);
    setWord(3, 11'h7FF, 16'h0006);
    for (int i = 4; i < NUM; i++) setWord(i, 11'($urandom), 16'h0000);
    checkOutput("src_fff9", {16'd0, mem[SRC + 7], mem[SRC + 6]}, 32'hFFF9);
    runAndCheck(1'b0);
    checkOutput("lit_mem0", {24'd0, mem[0]}, 32'hFF);
    checkOutput("lit_mem1", {24'd0, mem[1]}, 32'h07);
    checkOutput("lit_mem3", {24'd0, mem[3]}, 32'h47);
    checkOutput("lit_mem5", {24'd0, mem[5]}, 32'h47);
    checkOutput("lit_mem6", {24'd0, mem[6]}, 32'hFF);
    checkOutput("lit_mem7", {24'd0, mem[7]}, 32'h87);

    // Random runs; the second re-pulses Req mid-run.
    for (int m = 0; m < 4; m++) begin
      applyStimulus(m);
      runAndCheck(m == 1);
    end

    // All double errors.
    exp1 = 0; exp2 = 0;
    for (int i = 0; i < NUM; i++) setWord(i, 11'h7FF, 16'h0006);
    runAndCheck(1'b0);
`ifdef STATS_EN
    checkOutput("dbl_err2_lit", {27'd0, Err2_Cnt}, 32'd15);
    checkOutput("dbl_err1_lit", {27'd0, Err1_Cnt}, 32'd0);
`endif

    // Reset during WR_LO of message 4.
    applyStimulus(3);
    queueExpected();
    for (int a = 0; a < 30; a++) mem[DST + a] = 8'hA5;
    @(negedge Clk) Req = 1'b1;
    @(negedge Clk) Req = 1'b0;
    n = 0;
    while (n < 100 && !(Mem_WrEn && Mem_Addr == 8'(DST + 8))) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("reach_msg4", {31'd0, (n < 100)}, 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_wren", {31'd0, Mem_WrEn}, 32'd0);
    checkOutput("rst_mid_done", {31'd0, Done}, 32'd0);
    checkOutput("rst_mid_err1", {27'd0, Err1_Cnt}, 32'd0);
    expQ.delete();
    repeat (3) @(negedge Clk);
    for (int a = 0; a < 8; a++) begin
      checkOutput("rst_kept", {24'd0, mem[DST + a]}, {24'd0, (a % 2 == 0) ? expLo[a/2] : expHi[a/2]});
    end
    for (int a = 8; a < 30; a++) checkOutput("rst_untouched", {24'd0, mem[DST + a]}, 32'hA5);
    Reset_n = 1'b1;
    @(negedge Clk);
    checkOutput("post_rst_done", {31'd0, Done}, 32'd0);
    runAndCheck(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
